// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the WB/IF redirect logic.
//   evt_e         : redirect source selected by priority (ex > ertn > refetch)
//   ECODE_TLBR    : exception code that vectors to TLBRENTRY instead of EENTRY
//   CSR_EENTRY    : CSR number WB reads to source the normal exception entry
//   CSR_TLBRENTRY : CSR number WB reads to source the TLB-refill entry
//   evt_pick      : priority encoder over the three WB redirect events
//   sat_step      : one step of a counter saturating at 0 and at max
package cpu_pkg;

  typedef enum logic [1:0] {
    EVT_NONE    = 2'd0,
    EVT_EX      = 2'd1,
    EVT_ERTN    = 2'd2,
    EVT_REFETCH = 2'd3
  } evt_e;

  localparam logic [5:0]  ECODE_TLBR    = 6'h3f;
  localparam logic [13:0] CSR_EENTRY    = 14'h0c;
  localparam logic [13:0] CSR_TLBRENTRY = 14'h88;

  function automatic evt_e evt_pick(input logic ex, input logic ertn,
                                    input logic refetch);
    if (ex)           return EVT_EX;
    else if (ertn)    return EVT_ERTN;
    else if (refetch) return EVT_REFETCH;
    else              return EVT_NONE;
  endfunction

  function automatic int unsigned sat_step(input int unsigned cur,
                                           input logic inc, input logic dec,
                                           input int unsigned max);
    if (inc && !dec) return (cur >= max) ? max : cur + 32'd1;
    if (dec && !inc) return (cur == 32'd0) ? 32'd0 : cur - 32'd1;
    return cur;
  endfunction

endpackage

// File: rtl/sat_updown_cnt.sv
// Saturating up/down counter.
//   clk, resetn : clock, synchronous active-low reset
//   inc, dec    : count up / down; both together leave the count unchanged
//   cnt         : current count, held in [0, MAX]
module sat_updown_cnt
  import cpu_pkg::*;
#(
  parameter int unsigned MAX = 2,
  parameter int unsigned W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (!resetn) cnt <= '0;
    else         cnt <= W'(sat_step(32'(cnt), inc, dec, MAX));
  end

endmodule

// File: rtl/wb_flush_ctrl.sv
// Pipeline redirect / flush sequencer between WB and IF.
//   ex_valid/ex_entry, ertn_valid/era_pc, refetch_valid/refetch_pc :
//                    WB redirect events and their targets (ex > ertn > refetch)
//   inst_req_hs      : IF fetch request accepted this cycle
//   inst_data_ok     : fetch response returned this cycle (in order)
//   redirect_ready   : IF takes the pending redirect this cycle
//   flush_all        : same-cycle flush of all stage valids
//   redirect_valid/redirect_pc : pending redirect and its target
//   resp_discard     : current response belongs to a squashed fetch
//   busy             : redirect pending or stale responses still due
module wb_flush_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned MAX_OUTST = 2,
  parameter int unsigned CW        = $clog2(MAX_OUTST + 1)
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ex_valid,
  input  logic [31:0] ex_entry,
  input  logic        ertn_valid,
  input  logic [31:0] era_pc,
  input  logic        refetch_valid,
  input  logic [31:0] refetch_pc,
  input  logic        inst_req_hs,
  input  logic        inst_data_ok,
  input  logic        redirect_ready,
  output logic        flush_all,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        resp_discard,
  output logic        busy
);

  typedef enum logic {IDLE, REDIRECT} state_e;

  state_e      state, state_nxt;
  logic [31:0] pc_nxt;
  evt_e        evt_sel;
  logic        evt;
  logic [31:0] sel_pc;
  logic [CW-1:0] inflight;
  logic [CW-1:0] discard_load;
  logic [CW-1:0] discard_cnt;

  always_comb begin
    evt_sel = evt_pick(ex_valid, ertn_valid, refetch_valid);
    evt     = (evt_sel != EVT_NONE);
    case (evt_sel)
      EVT_EX:      sel_pc = ex_entry;
      EVT_ERTN:    sel_pc = era_pc;
      EVT_REFETCH: sel_pc = refetch_pc;
      default:     sel_pc = '0;
    endcase
  end

  assign flush_all = evt;

  always_comb begin
    state_nxt = state;
    pc_nxt    = redirect_pc;
    case (state)
      IDLE: begin
        if (evt) begin
          state_nxt = REDIRECT;
          pc_nxt    = sel_pc;
        end
      end
      REDIRECT: begin
        // A fresh event overrides the unaccepted target even if IF is ready.
        if (evt)                 pc_nxt    = sel_pc;
        else if (redirect_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= IDLE;
      redirect_pc <= '0;
    end else begin
      state       <= state_nxt;
      redirect_pc <= pc_nxt;
    end
  end

  assign redirect_valid = (state == REDIRECT);

  sat_updown_cnt #(
    .MAX (MAX_OUTST),
    .W   (CW)
  ) u_inflight (
    .clk    (clk),
    .resetn (resetn),
    .inc    (inst_req_hs),
    .dec    (inst_data_ok),
    .cnt    (inflight)
  );

  // Everything outstanding after this cycle's handshakes is stale on a flush.
  assign discard_load = CW'(sat_step(32'(inflight), inst_req_hs, inst_data_ok,
                                     MAX_OUTST));

  always_ff @(posedge clk) begin
    if (!resetn)                             discard_cnt <= '0;
    else if (evt)                            discard_cnt <= discard_load;
    else if (inst_data_ok && discard_cnt != '0) discard_cnt <= discard_cnt - CW'(1);
  end

  assign resp_discard = inst_data_ok && (discard_cnt != '0);
  assign busy         = redirect_valid || (discard_cnt != '0);

endmodule
